// File: rtl/conv_mac_sequencer.sv
// Convolution MAC sequencer: walks filter taps per output position, issues X/F read
// addresses, aligns MAC strobes to the 1-cycle read latency. Optional macro: CONV_STALL_CNT_EN.
module conv_mac_sequencer #(
    parameter int F_MEM_SIZE       = 4,
    parameter int X_MEM_SIZE       = 8,
    parameter int X_MEM_ADDR_WIDTH = 3,
    parameter int F_MEM_ADDR_WIDTH = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        conv_start,
    input  logic                        m_ready_y,
    output logic [X_MEM_ADDR_WIDTH-1:0] x_addr,
    output logic [F_MEM_ADDR_WIDTH-1:0] f_addr,
    output logic                        mac_en,
    output logic                        mac_clear,
    output logic                        m_valid_y,
`ifdef CONV_STALL_CNT_EN
    output logic [15:0]                 stall_cnt,
`endif
    output logic                        conv_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_VALID,
        S_DONE
    } state_t;

    localparam logic [X_MEM_ADDR_WIDTH-1:0] LAST_OUT = X_MEM_ADDR_WIDTH'(X_MEM_SIZE - F_MEM_SIZE);
    localparam logic [F_MEM_ADDR_WIDTH-1:0] LAST_TAP = F_MEM_ADDR_WIDTH'(F_MEM_SIZE - 1);

    state_t                      state_q, state_d;
    logic [F_MEM_ADDR_WIDTH-1:0] tap_q, tap_d;
    logic [X_MEM_ADDR_WIDTH-1:0] out_idx_q, out_idx_d;
    logic [X_MEM_ADDR_WIDTH-1:0] x_addr_q, x_addr_d;
    logic [F_MEM_ADDR_WIDTH-1:0] f_addr_q, f_addr_d;
    logic                        mac_en_q, mac_en_d;
    logic                        mac_clear_q, mac_clear_d;
    logic                        m_valid_y_q, m_valid_y_d;
    logic                        conv_done_q, conv_done_d;
    logic                        start_armed_q;
    logic                        start_edge;

    // Armed only after conv_start has been seen low, so a level held across reset never starts a run.
    assign start_edge = conv_start && start_armed_q;

    always_comb begin
        state_d     = state_q;
        tap_d       = tap_q;
        out_idx_d   = out_idx_q;
        x_addr_d    = x_addr_q;
        f_addr_d    = f_addr_q;
        mac_en_d    = 1'b0;
        mac_clear_d = 1'b0;
        m_valid_y_d = 1'b0;
        conv_done_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_edge) begin
                    state_d   = S_ISSUE;
                    tap_d     = '0;
                    out_idx_d = '0;
                end
            end
            S_ISSUE: begin
                mac_en_d    = 1'b1;
                mac_clear_d = (tap_q == '0);
                if (tap_q == LAST_TAP) begin
                    state_d = S_WAIT;
                end else begin
                    tap_d = tap_q + F_MEM_ADDR_WIDTH'(1);
                end
            end
            S_WAIT: begin
                state_d = S_VALID;
            end
            S_VALID: begin
                if (m_ready_y) begin
                    if (out_idx_q == LAST_OUT) begin
                        state_d = S_DONE;
                    end else begin
                        state_d   = S_ISSUE;
                        out_idx_d = out_idx_q + X_MEM_ADDR_WIDTH'(1);
                        tap_d     = '0;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort discards the run, including the MAC strobe still pending from the last issue.
        if (state_q != S_IDLE && !conv_start) begin
            state_d     = S_IDLE;
            tap_d       = '0;
            out_idx_d   = '0;
            mac_en_d    = 1'b0;
            mac_clear_d = 1'b0;
        end

        case (state_d)
            S_ISSUE: begin
                x_addr_d = out_idx_d + X_MEM_ADDR_WIDTH'(tap_d);
                f_addr_d = tap_d;
            end
            S_IDLE, S_DONE: begin
                x_addr_d = '0;
                f_addr_d = '0;
            end
            default: begin
            end
        endcase

        m_valid_y_d = (state_d == S_VALID);
        conv_done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            tap_q         <= '0;
            out_idx_q     <= '0;
            x_addr_q      <= '0;
            f_addr_q      <= '0;
            mac_en_q      <= 1'b0;
            mac_clear_q   <= 1'b0;
            m_valid_y_q   <= 1'b0;
            conv_done_q   <= 1'b0;
            start_armed_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            tap_q         <= tap_d;
            out_idx_q     <= out_idx_d;
            x_addr_q      <= x_addr_d;
            f_addr_q      <= f_addr_d;
            mac_en_q      <= mac_en_d;
            mac_clear_q   <= mac_clear_d;
            m_valid_y_q   <= m_valid_y_d;
            conv_done_q   <= conv_done_d;
            start_armed_q <= !conv_start;
        end
    end

    assign x_addr    = x_addr_q;
    assign f_addr    = f_addr_q;
    assign mac_en    = mac_en_q;
    assign mac_clear = mac_clear_q;
    assign m_valid_y = m_valid_y_q;
    assign conv_done = conv_done_q;

`ifdef CONV_STALL_CNT_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else if (state_q == S_IDLE && start_edge) begin
            stall_cnt_q <= '0;
        end else if (m_valid_y_q && !m_ready_y && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_conv_mac_sequencer.sv
// Directed bench for conv_mac_sequencer (F=4, X=8): per-cycle vector table plus
// hand-written latency/count sequence; checks stall_cnt when CONV_STALL_CNT_EN is defined.
module tb_conv_mac_sequencer;

    logic       clk;
    logic       reset;
    logic       conv_start;
    logic       m_ready_y;
    logic [2:0] x_addr;
    logic [1:0] f_addr;
    logic       mac_en;
    logic       mac_clear;
    logic       m_valid_y;
    logic       conv_done;
`ifdef CONV_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    conv_mac_sequencer #(
        .F_MEM_SIZE      (4),
        .X_MEM_SIZE      (8),
        .X_MEM_ADDR_WIDTH(3),
        .F_MEM_ADDR_WIDTH(2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .conv_start(conv_start),
        .m_ready_y (m_ready_y),
        .x_addr    (x_addr),
        .f_addr    (f_addr),
        .mac_en    (mac_en),
        .mac_clear (mac_clear),
        .m_valid_y (m_valid_y),
`ifdef CONV_STALL_CNT_EN
        .stall_cnt (stall_cnt),
`endif
        .conv_done (conv_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs applied before an edge, expected outputs observed just after that edge.
    typedef struct {
        logic       rst;
        logic       start;
        logic       rdy;
        logic [2:0] x;
        logic [1:0] f;
        logic       en;
        logic       clr;
        logic       vld;
        logic       done;
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic push(input logic rst, input logic s, input logic rdy, input int x, input int f,
                        input logic en, input logic clr, input logic vld, input logic done);
        vec_t v;
        v.rst   = rst;
        v.start = s;
        v.rdy   = rdy;
        v.x     = 3'(x);
        v.f     = 2'(f);
        v.en    = en;
        v.clr   = clr;
        v.vld   = vld;
        v.done  = done;
        vecs.push_back(v);
    endtask

    task automatic push_zero(input logic rst, input logic s);
        push(rst, s, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Run with conv_start high: 5 outputs x (ISSUE 4, WAIT 1, VALID 1), optional stall rows
    // after VALID of output stall_k, then DONE and IDLE. cut >= 0 truncates to that many rows.
    task automatic gen_seq(input int stall_k, input int stall_n, input int cut);
        int n;
        n = 0;
        for (int k = 0; k < 5; k++) begin
            for (int p = 0; p < 6; p++) begin
                if (cut >= 0 && n >= cut) return;
                push(1'b0, 1'b1, 1'b1, (p <= 3) ? k + p : k + 3, (p <= 3) ? p : 3,
                     (p >= 1 && p <= 4), (p == 1), (p == 5), 1'b0);
                n++;
                if (p == 5 && k == stall_k) begin
                    for (int s = 0; s < stall_n; s++) begin
                        if (cut >= 0 && n >= cut) return;
                        push(1'b0, 1'b1, 1'b0, k + 3, 3, 1'b0, 1'b0, 1'b1, 1'b0);
                        n++;
                    end
                end
            end
        end
        if (cut < 0) begin
            push(1'b0, 1'b1, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
            push_zero(1'b0, 1'b1);
        end
    endtask

    task automatic apply(input logic r, input logic s, input logic rdy);
        reset      = r;
        conv_start = s;
        m_ready_y  = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end else begin
            $display("[TB] %s: %0d ok", name, got);
        end
    endtask

    initial begin
        int steps, first_vld, done_at, nv, ne, nc;
        logic [8:0] got, exp;

        reset      = 1'b1;
        conv_start = 1'b0;
        m_ready_y  = 1'b1;

        // Reset state, then arm with conv_start low.
        push_zero(1'b1, 1'b0);
        push_zero(1'b1, 1'b0);
        push_zero(1'b0, 1'b0);
        // Full run with no backpressure, then conv_start held high: no restart.
        gen_seq(-1, 0, -1);
        push_zero(1'b0, 1'b1);
        push_zero(1'b0, 1'b1);
        // Abort during output 1 ISSUE, then restart from output 0.
        push_zero(1'b0, 1'b0);
        gen_seq(-1, 0, 8);
        push_zero(1'b0, 1'b0);
        push_zero(1'b0, 1'b0);
        gen_seq(-1, 0, 6);
        // Reset while VALID; conv_start stays high afterwards: no start without a toggle.
        push_zero(1'b1, 1'b1);
        push_zero(1'b0, 1'b1);
        push_zero(1'b0, 1'b1);
        push_zero(1'b0, 1'b1);
        // Toggle, then full run with 3 stall cycles on output 2.
        push_zero(1'b0, 1'b0);
        gen_seq(2, 3, -1);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].rst, vecs[i].start, vecs[i].rdy);
            got = {x_addr, f_addr, mac_en, mac_clear, m_valid_y, conv_done};
            exp = {vecs[i].x, vecs[i].f, vecs[i].en, vecs[i].clr, vecs[i].vld, vecs[i].done};
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL vec%0d: got x=%0d f=%0d en=%b clr=%b vld=%b done=%b, expected x=%0d f=%0d en=%b clr=%b vld=%b done=%b",
                         i, x_addr, f_addr, mac_en, mac_clear, m_valid_y, conv_done,
                         vecs[i].x, vecs[i].f, vecs[i].en, vecs[i].clr, vecs[i].vld, vecs[i].done);
            end else begin
                $display("[TB] vec%0d rst=%b start=%b rdy=%b -> x=%0d f=%0d en=%b clr=%b vld=%b done=%b ok",
                         i, vecs[i].rst, vecs[i].start, vecs[i].rdy,
                         x_addr, f_addr, mac_en, mac_clear, m_valid_y, conv_done);
            end
            if (mac_en && m_valid_y) begin
                n_tests++;
                n_fail++;
                $display("FAIL en_vs_vld vec%0d: got mac_en=1 with m_valid_y=1, expected not both", i);
            end
        end

`ifdef CONV_STALL_CNT_EN
        check("stall_cnt_after_stall_run", int'(stall_cnt), 3);
`endif

        // Latency and strobe counts over one unstalled run, bounded cycle budget.
        apply(1'b0, 1'b0, 1'b1);
        apply(1'b0, 1'b1, 1'b1);
        steps     = 0;
        first_vld = -1;
        done_at   = -1;
        nv        = 0;
        ne        = 0;
        nc        = 0;
        while (done_at < 0 && steps < 100) begin
            apply(1'b0, 1'b1, 1'b1);
            steps++;
            if (m_valid_y) begin
                nv++;
                if (first_vld < 0) first_vld = steps;
            end
            if (mac_en) ne++;
            if (mac_clear) nc++;
            if (conv_done) done_at = steps;
        end
        check("first_valid_latency", first_vld, 5);
        check("done_latency", done_at, 30);
        check("valid_cycles", nv, 5);
        check("mac_en_cycles", ne, 20);
        check("mac_clear_cycles", nc, 5);
        apply(1'b0, 1'b1, 1'b1);
        check("done_single_pulse", int'(conv_done), 0);
`ifdef CONV_STALL_CNT_EN
        check("stall_cnt_cleared_on_start", int'(stall_cnt), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
